// File: rtl/transmisor.sv
// Parallel-to-serial transmitter feeding the receptor shift register: valid/ready word in, one bit per clock out.
// Optional TRANSMISOR_FRAMECNT_EN adds a 16-bit count of completed frames.
module transmisor #(
  parameter int SIZESREG   = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SIZESREG-1:0] data_in,
  input  logic                load,
  output logic                ready,
  output logic                enable,
  output logic                signal_out,
  output logic                done
`ifdef TRANSMISOR_FRAMECNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  localparam int CNT_W = $clog2(SIZESREG + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZESREG - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t              state, state_d;
  logic [SIZESREG-1:0] sreg, sreg_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [7:0]          gap_cnt, gap_cnt_d;
  logic                ready_d, enable_d, signal_d, done_d;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset is synchronous; the plain datapath registers are cleared too so the line idles low.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ready      <= 1'b1;
      enable     <= 1'b0;
      signal_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      ready      <= ready_d;
      enable     <= enable_d;
      signal_out <= signal_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_d = GAP;
      GAP:     if (gap_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    sreg_d    = sreg;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    ready_d   = 1'b0;
    enable_d  = 1'b0;
    signal_d  = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          sreg_d    = data_in;
          bit_cnt_d = '0;
          enable_d  = 1'b1;
          signal_d  = MSB_FIRST ? data_in[SIZESREG-1] : data_in[0];
        end else begin
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        bit_cnt_d = bit_cnt + 1'b1;
        sreg_d    = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        if (bit_cnt == LAST_BIT) begin
          done_d    = 1'b1;
          gap_cnt_d = GAP_LOAD;
        end else begin
          // The bit presented next is the one that lands on the output end after this shift.
          enable_d = 1'b1;
          signal_d = MSB_FIRST ? sreg_d[SIZESREG-1] : sreg_d[0];
        end
      end
      GAP: begin
        if (gap_cnt == '0) ready_d = 1'b1;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TRANSMISOR_FRAMECNT_EN
  // Counts only frames that reach their done pulse; an aborted frame never sets done_d.
  always_ff @(posedge CLK) begin
    if (!RST_N)      frame_cnt <= '0;
    else if (done_d) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_transmisor.sv
// Self-checking bench for transmisor: three instances (MSB-first gap 3, LSB-first gap 1, one-bit frames)
// checked every cycle against a frame-timeline model, plus directed vector table and corner sequences.
module tb_transmisor;

  localparam int S     = 16;
  localparam int GAP_A = 3;
  localparam int GAP_B = 1;
  localparam int GAP_C = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic [0:0]  data_c = '0;
  logic        load_c = 1'b0;

  logic ready_a, enable_a, so_a, done_a;
  logic ready_b, enable_b, so_b, done_b;
  logic ready_c, enable_c, so_c, done_c;
`ifdef TRANSMISOR_FRAMECNT_EN
  logic [15:0] fcnt_a, fcnt_b, fcnt_c;
`endif

  always #5 CLK = ~CLK;

  transmisor #(.SIZESREG(S), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP_A)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .data_in(data_in), .load(load),
    .ready(ready_a), .enable(enable_a), .signal_out(so_a), .done(done_a)
`ifdef TRANSMISOR_FRAMECNT_EN
    , .frame_cnt(fcnt_a)
`endif
  );

  transmisor #(.SIZESREG(S), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP_B)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .data_in(data_in), .load(load),
    .ready(ready_b), .enable(enable_b), .signal_out(so_b), .done(done_b)
`ifdef TRANSMISOR_FRAMECNT_EN
    , .frame_cnt(fcnt_b)
`endif
  );

  transmisor #(.SIZESREG(1), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP_C)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .data_in(data_c), .load(load_c),
    .ready(ready_c), .enable(enable_c), .signal_out(so_c), .done(done_c)
`ifdef TRANSMISOR_FRAMECNT_EN
    , .frame_cnt(fcnt_c)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame is just its age in cycles since acceptance; outputs follow from the age.
  typedef struct {
    int          age;   // -1 when idle
    logic [15:0] word;
    logic [15:0] fcnt;
  } model_t;

  function automatic model_t step(model_t m, int s, int gap, logic rst_n, logic ld, logic [15:0] d);
    model_t r = m;
    if (!rst_n) begin
      r.age  = -1;
      r.fcnt = '0;
    end else if (r.age < 0) begin
      if (ld) begin
        r.age  = 0;
        r.word = d;
      end
    end else begin
      r.age++;
      if (r.age == s) r.fcnt++;
      if (r.age >= s + gap) r.age = -1;
    end
    return r;
  endfunction

  // Packed as {ready, enable, signal_out, done}.
  function automatic logic [3:0] expect_outs(model_t m, int s, bit msb);
    if (m.age < 0)  return 4'b1000;
    if (m.age < s)  return {2'b01, (msb ? m.word[s-1-m.age] : m.word[m.age]), 1'b0};
    if (m.age == s) return 4'b0001;
    return 4'b0000;
  endfunction

  model_t ma = '{age: -1, word: '0, fcnt: '0};
  model_t mb = '{age: -1, word: '0, fcnt: '0};
  model_t mc = '{age: -1, word: '0, fcnt: '0};

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    ma  <= step(ma, S, GAP_A, RST_N, load, data_in);
    mb  <= step(mb, S, GAP_B, RST_N, load, data_in);
    mc  <= step(mc, 1, GAP_C, RST_N, load_c, {15'b0, data_c});
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      check("outs_a", {ready_a, enable_a, so_a, done_a}, expect_outs(ma, S, 1'b1));
      check("outs_b", {ready_b, enable_b, so_b, done_b}, expect_outs(mb, S, 1'b0));
      check("outs_c", {ready_c, enable_c, so_c, done_c}, expect_outs(mc, 1, 1'b1));
`ifdef TRANSMISOR_FRAMECNT_EN
      check("fcnt_a", fcnt_a, ma.fcnt);
      check("fcnt_b", fcnt_b, mb.fcnt);
      check("fcnt_c", fcnt_c, mc.fcnt);
`endif
    end
  end

  // Receptor stand-ins: shift in on enable, hand the word over on done.
  logic [15:0] rx_a = '0, rx_b = '0;
  int          len_a = 0, len_b = 0;
  logic [15:0] q_frame_a[$], q_frame_b[$];
  int          q_len_a[$], q_len_b[$];

  always @(posedge CLK) begin
    if (!RST_N) begin
      rx_a <= '0; len_a <= 0; rx_b <= '0; len_b <= 0;
    end else begin
      if (enable_a) begin rx_a <= {rx_a[14:0], so_a}; len_a <= len_a + 1; end
      if (enable_b) begin rx_b <= {rx_b[14:0], so_b}; len_b <= len_b + 1; end
      if (done_a) begin q_frame_a.push_back(rx_a); q_len_a.push_back(len_a); rx_a <= '0; len_a <= 0; end
      if (done_b) begin q_frame_b.push_back(rx_b); q_len_b.push_back(len_b); rx_b <= '0; len_b <= 0; end
    end
  end

  // Timing monitor for instance A: acceptance cycles, done-to-ready distance, enable-low runs.
  int  q_acc_a[$], q_gap_a[$], q_low_a[$];
  bit  prev_ready_a = 1'b1;
  bit  seen_en_a = 1'b0;
  int  done_cyc_a = 0;
  int  low_run_a = 0;

  always @(negedge CLK) begin
    if (chk_on) begin
      if (prev_ready_a && !ready_a) q_acc_a.push_back(cyc);
      if (done_a) done_cyc_a = cyc;
      if (!prev_ready_a && ready_a) q_gap_a.push_back(cyc - done_cyc_a);
      if (enable_a) begin
        if (seen_en_a && low_run_a > 0) q_low_a.push_back(low_run_a);
        low_run_a = 0;
        seen_en_a = 1'b1;
      end else begin
        low_run_a++;
      end
      prev_ready_a = ready_a;
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [15:0] str_msb;  // serial stream from A, first bit at [15]
    logic [15:0] str_lsb;  // serial stream from B, first bit at [15]
    int          poke;     // SHIFT cycle at which a second word is offered, 0 = none
  } vec_t;

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(ready_a && ready_b) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", {ready_a, ready_b}, 2'b11);
  endtask

  task automatic wait_frames(input int na, input int nb, input int budget);
    int n = 0;
    while ((q_frame_a.size() < na || q_frame_b.size() < nb) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("frames_a_arrived", q_frame_a.size(), na);
    check("frames_b_arrived", q_frame_b.size(), nb);
  endtask

  task automatic flush_queues();
    q_frame_a.delete(); q_frame_b.delete(); q_len_a.delete(); q_len_b.delete();
    q_acc_a.delete(); q_gap_a.delete(); q_low_a.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[5];
    vecs[0] = '{data: 16'hA5C3, str_msb: 16'hA5C3, str_lsb: 16'hC3A5, poke: 0};
    vecs[1] = '{data: 16'h1234, str_msb: 16'h1234, str_lsb: 16'h2C48, poke: 5};
    vecs[2] = '{data: 16'h00FF, str_msb: 16'h00FF, str_lsb: 16'hFF00, poke: 0};
    vecs[3] = '{data: 16'hFF00, str_msb: 16'hFF00, str_lsb: 16'h00FF, poke: 0};
    vecs[4] = '{data: 16'h0001, str_msb: 16'h0001, str_lsb: 16'h8000, poke: 0};

    // Reset for two edges, checking the reset state explicitly.
    @(posedge CLK);
    #1 chk_on = 1'b1;
    @(negedge CLK);
    check("reset_a", {ready_a, enable_a, so_a, done_a}, 4'b1000);
    check("reset_b", {ready_b, enable_b, so_b, done_b}, 4'b1000);
    check("reset_c", {ready_c, enable_c, so_c, done_c}, 4'b1000);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed vectors, including a second word offered mid-frame that must be dropped.
    foreach (vecs[i]) begin
      flush_queues();
      load = 1'b1; data_in = vecs[i].data;
      @(negedge CLK);
      load = 1'b0;
      if (vecs[i].poke > 0) begin
        repeat (vecs[i].poke - 1) @(negedge CLK);
        load = 1'b1; data_in = 16'hFFFF;
        @(negedge CLK);
        load = 1'b0;
      end
      wait_frames(1, 1, 60);
      if (q_frame_a.size() > 0) begin
        check("stream_a", q_frame_a[0], vecs[i].str_msb);
        check("enable_len_a", q_len_a[0], S);
      end
      if (q_frame_b.size() > 0) begin
        check("stream_b", q_frame_b[0], vecs[i].str_lsb);
        check("enable_len_b", q_len_b[0], S);
      end
      wait_idle(40);
      repeat (4) @(negedge CLK);
      check("no_extra_frame_a", q_frame_a.size(), 1);
      check("no_extra_frame_b", q_frame_b.size(), 1);
    end

    // Load on the edge that returns A from GAP to IDLE is ignored.
    load = 1'b1; data_in = 16'h5A5A;
    @(negedge CLK);
    load = 1'b0;
    repeat (S + GAP_A - 1) @(negedge CLK);
    load = 1'b1; data_in = 16'h3C3C;
    @(negedge CLK);
    load = 1'b0;
    @(negedge CLK);
    check("gap_edge_load_ignored", {ready_a, enable_a}, 2'b10);
    wait_idle(40);
    repeat (3) @(negedge CLK);

    // Back-to-back frames on A with load held high.
    flush_queues();
    @(negedge CLK);
    load = 1'b1; data_in = 16'h00FF;
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (ready_a && n < 10);
      data_in = 16'hFF00;
      n = 0;
      while (!ready_a && n < 40) begin @(negedge CLK); n++; end
      n = 0;
      do begin @(negedge CLK); n++; end while (ready_a && n < 10);
    end
    load = 1'b0;
    wait_idle(60);
    repeat (2) @(negedge CLK);
    check("b2b_accepts", q_acc_a.size(), 2);
    if (q_acc_a.size() == 2) check("b2b_period", q_acc_a[1] - q_acc_a[0], S + GAP_A + 1);
    check("b2b_frames", q_frame_a.size(), 2);
    if (q_frame_a.size() == 2) begin
      check("b2b_word0", q_frame_a[0], 16'h00FF);
      check("b2b_word1", q_frame_a[1], 16'hFF00);
    end
    if (q_gap_a.size() > 0) check("b2b_gap_cycles", q_gap_a[0], GAP_A);
    // Between frames enable is low for the GAP cycles plus the idle acceptance cycle.
    check("b2b_low_runs", q_low_a.size(), 2);
    if (q_low_a.size() == 2) check("b2b_enable_low", q_low_a[1], GAP_A + 1);

    // Reset in the 8th SHIFT cycle aborts the frame with no done pulse.
    flush_queues();
    @(negedge CLK);
    load = 1'b1; data_in = 16'hBEEF;
    @(negedge CLK);
    load = 1'b0;
    repeat (7) @(negedge CLK);
    check("pre_abort_enable", {enable_a, enable_b}, 2'b11);
    RST_N = 1'b0;
    @(negedge CLK);
    check("abort_a", {enable_a, so_a, done_a}, 3'b000);
    check("abort_b", {enable_b, so_b, done_b}, 3'b000);
    RST_N = 1'b1;
    @(negedge CLK);
    check("abort_ready", {ready_a, ready_b}, 2'b11);
    repeat (S + 4) @(negedge CLK);
    check("abort_no_done", q_frame_a.size() + q_frame_b.size(), 0);

    // Random traffic with occasional resets, checked by the per-cycle model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST_N   = ($urandom_range(0, 199) != 0);
      load    = ($urandom_range(0, 3) == 0);
      data_in = 16'($urandom);
      load_c  = ($urandom_range(0, 1) == 1);
      data_c  = 1'($urandom);
    end
    @(negedge CLK);
    RST_N = 1'b1; load = 1'b0; load_c = 1'b0;
    wait_idle(60);

`ifdef TRANSMISOR_FRAMECNT_EN
    // Three frames from reset: counter reads 3.
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge CLK);
      load = 1'b1; data_in = 16'($urandom);
      @(negedge CLK);
      load = 1'b0;
      wait_idle(60);
    end
    check("frame_cnt_three", fcnt_a, 16'd3);
`endif

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
